// File: rtl/mul_div_seq_pkg.sv
// Shared types and constants for the multiply/divide sequencer and its ALU.
package mul_div_pkg;

    // Datapath word width; the ALU is built from nine 4-bit slices.
    localparam int W = 36;

    typedef enum logic [2:0] {
        IDLE,
        MSTEP,
        DSTEP,
        DFIX,
        DSIGN,
        DONE
    } state_t;

    // ALU function word as {S[3:0], boole, cin}.
    typedef struct packed {
        logic [3:0] s;
        logic       boole;
        logic       cin;
    } alu_fn_t;

    localparam alu_fn_t FN_ADD   = alu_fn_t'(6'b0110_0_0);
    localparam alu_fn_t FN_SUB   = alu_fn_t'(6'b1001_0_1);
    localparam alu_fn_t FN_PASSA = alu_fn_t'(6'b1111_0_1);

    // Magnitude of a two's-complement word; the most negative value maps to 2^(W-1) unsigned.
    function automatic logic [W-1:0] abs_w(input logic [W-1:0] x);
        return x[W-1] ? -x : x;
    endfunction

endpackage

// File: rtl/mul_div_seq_if.sv
// Start/done handshake and operand/result bus between EBOX control and the sequencer.
interface mul_div_seq_if;
    import mul_div_pkg::*;

    logic         start;
    logic         op;
    logic [W-1:0] a_hi;
    logic [W-1:0] a_lo;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         ovf;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    modport master (
        output start, op, a_hi, a_lo, b,
        input  busy, done, ovf, hi, lo
    );

    modport slave (
        input  start, op, a_hi, a_lo, b,
        output busy, done, ovf, hi, lo
    );

endinterface

// File: rtl/mul_div_seq_alu36.sv
// 36-bit ripple-carry ALU made of nine mc10181-style 4-bit slices.

// One 4-bit slice. The sum is formed as (A | X) + (A & Y) + cn, where X and Y
// pick B, ~B, 0 or 1 from the select bits. With boole set the inter-bit carries
// are suppressed and the slice produces the carry-free sum bits. Group
// lookahead outputs are not modelled because the slices are ripple-chained.
module mc10181 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic [3:0] i_s,
    input  logic       i_m,
    input  logic       i_cn,
    output logic [3:0] o_f,
    output logic       o_cout
);
    logic [3:0] w_x;
    logic [3:0] w_y;
    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [4:0] w_sum;

    assign w_x   = (i_b & {4{i_s[1]}}) | (~i_b & {4{i_s[0]}});
    assign w_y   = (i_b & {4{i_s[2]}}) | (~i_b & {4{i_s[3]}});
    assign w_p   = i_a | w_x;
    assign w_g   = i_a & w_y;
    assign w_sum = {1'b0, w_p} + {1'b0, w_g} + {4'b0000, i_cn};

    assign o_f    = i_m ? (w_p ^ w_g) : w_sum[3:0];
    assign o_cout = i_m ? 1'b0 : w_sum[4];
endmodule

module alu36
    import mul_div_pkg::*;
(
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [3:0]   i_s,
    input  logic         i_boole,
    input  logic         i_cin,
    output logic [W-1:0] f,
    output logic         cout
);
    logic [9:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar i = 0; i < 9; i++) begin : g_slice
        mc10181 u_slice (
            .i_a    (i_a[4*i +: 4]),
            .i_b    (i_b[4*i +: 4]),
            .i_s    (i_s),
            .i_m    (i_boole),
            .i_cn   (w_c[i]),
            .o_f    (f[4*i +: 4]),
            .o_cout (w_c[i+1])
        );
    end

    assign cout = w_c[9];
endmodule

// File: rtl/mul_div_seq.sv
// Iterative signed multiply (radix-2 Booth) and divide (non-restoring on
// magnitudes) sequencer. Every step goes registers -> alu36 -> registers.
module mul_div_seq
    import mul_div_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    mul_div_seq_if.slave bus
);
    state_t         r_state;
    state_t         w_next;
    logic [5:0]     r_cnt;
    logic [W-1:0]   r_ar;
    logic [W-1:0]   r_mq;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_hi;
    logic [W-1:0]   r_lo;
    logic           r_rtop;
    logic           r_prev;
    logic           r_negq;
    logic           r_negr;
    logic           r_ovf;

    alu_fn_t        w_fn;
    logic [W-1:0]   w_alu_a;
    logic [W-1:0]   w_alu_b;
    logic [W-1:0]   w_f;
    logic [W-1:0]   w_fneg;
    logic           w_cout;
    logic           w_unused_cout;
    logic           w_opsign;
    logic           w_shin;
    logic           w_rtop_new;
    logic           w_last;
    logic [2*W-1:0] w_dvd;
    logic [2*W-1:0] w_mag;
    logic [W-1:0]   w_absb;
    logic           w_dovf;

    assign w_last = (r_cnt == 6'd35);

    // Divide operand conditioning: 72-bit dividend magnitude, divisor magnitude, overflow.
    assign w_dvd  = {bus.a_hi, bus.a_lo};
    assign w_mag  = w_dvd[2*W-1] ? -w_dvd : w_dvd;
    assign w_absb = abs_w(bus.b);
    assign w_dovf = (bus.b == '0) || (w_mag[2*W-1:W] >= w_absb);

    // Booth shift-in is the true sign of the 37-bit sum: F[35] corrected on overflow.
    assign w_opsign = (w_fn == FN_ADD) ? r_b[W-1] :
                      ((w_fn == FN_SUB) ? ~r_b[W-1] : 1'b1);
    assign w_shin   = w_f[W-1] ^ ((r_ar[W-1] == w_opsign) && (w_f[W-1] != r_ar[W-1]));

    // Partial remainder bit 36: shifted-in top bit, operand bit 36 (1 for ~B), carry out of slice 8.
    assign w_rtop_new = r_ar[W-1] ^ (w_fn == FN_SUB) ^ w_cout;

    alu36 u_alu (
        .i_a     (w_alu_a),
        .i_b     (w_alu_b),
        .i_s     (w_fn.s),
        .i_boole (w_fn.boole),
        .i_cin   (w_fn.cin),
        .f       (w_f),
        .cout    (w_cout)
    );

    // The remainder is negated in the same DSIGN cycle as the quotient, so it gets its own ALU.
    alu36 u_alu_neg (
        .i_a     ('0),
        .i_b     (r_ar),
        .i_s     (FN_SUB.s),
        .i_boole (FN_SUB.boole),
        .i_cin   (FN_SUB.cin),
        .f       (w_fneg),
        .cout    (w_unused_cout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state: 36 steps per operation, divide adds fix-up and sign cycles.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = bus.op ? DSTEP : MSTEP;
            MSTEP:   if (w_last) w_next = DONE;
            DSTEP:   if (r_ovf) w_next = DONE;
                     else if (w_last) w_next = DFIX;
            DFIX:    w_next = DSIGN;
            DSIGN:   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs: handshake decode and ALU function/operand selection per state.
    always_comb begin
        bus.busy = (r_state != IDLE);
        bus.done = (r_state == DONE);
        w_fn     = FN_PASSA;
        w_alu_a  = r_ar;
        w_alu_b  = r_b;
        case (r_state)
            MSTEP: begin
                case ({r_mq[0], r_prev})
                    2'b10:   w_fn = FN_SUB;
                    2'b01:   w_fn = FN_ADD;
                    default: w_fn = FN_PASSA;
                endcase
            end
            DSTEP: begin
                w_alu_a = {r_ar[W-2:0], r_mq[W-1]};
                w_fn    = r_rtop ? FN_ADD : FN_SUB;
            end
            DFIX: begin
                w_fn = FN_ADD;
            end
            DSIGN: begin
                w_alu_a = '0;
                w_alu_b = r_mq;
                w_fn    = FN_SUB;
            end
            default: ;
        endcase
    end

    // Datapath: operand load on accepted start, per-step AR/MQ/R update, result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_ar   <= '0;
            r_mq   <= '0;
            r_b    <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_rtop <= 1'b0;
            r_prev <= 1'b0;
            r_negq <= 1'b0;
            r_negr <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_cnt  <= '0;
                        r_rtop <= 1'b0;
                        r_prev <= 1'b0;
                        r_ovf  <= 1'b0;
                        if (!bus.op) begin
                            r_ar <= '0;
                            r_mq <= bus.b;
                            r_b  <= bus.a_lo;
                        end else if (w_dovf) begin
                            r_ovf <= 1'b1;
                            r_ar  <= bus.a_hi;
                            r_mq  <= bus.a_lo;
                            r_b   <= w_absb;
                        end else begin
                            r_ar   <= w_mag[2*W-1:W];
                            r_mq   <= w_mag[W-1:0];
                            r_b    <= w_absb;
                            r_negq <= bus.a_hi[W-1] ^ bus.b[W-1];
                            r_negr <= bus.a_hi[W-1];
                        end
                    end
                end
                MSTEP: begin
                    r_ar   <= {w_shin, w_f[W-1:1]};
                    r_mq   <= {w_f[0], r_mq[W-1:1]};
                    r_prev <= r_mq[0];
                    r_cnt  <= r_cnt + 6'd1;
                    if (w_last) begin
                        r_hi <= {w_shin, w_f[W-1:1]};
                        r_lo <= {w_f[0], r_mq[W-1:1]};
                    end
                end
                DSTEP: begin
                    if (r_ovf) begin
                        r_hi <= r_ar;
                        r_lo <= r_mq;
                    end else begin
                        r_rtop <= w_rtop_new;
                        r_ar   <= w_f;
                        r_mq   <= {r_mq[W-2:0], ~w_rtop_new};
                        r_cnt  <= r_cnt + 6'd1;
                    end
                end
                DFIX: begin
                    if (r_rtop) begin
                        r_ar   <= w_f;
                        r_rtop <= 1'b0;
                    end
                end
                DSIGN: begin
                    r_hi <= r_negq ? w_f : r_mq;
                    r_lo <= r_negr ? w_fneg : r_ar;
                end
                default: ;
            endcase
        end
    end

    assign bus.hi  = r_hi;
    assign bus.lo  = r_lo;
    assign bus.ovf = r_ovf;

endmodule

// File: tb/tb_mul_div_seq.sv
// Scoreboard bench for mul_div_seq: stimulus pushes expected results, a monitor
// pops and compares them whenever done is presented.
module tb_mul_div_seq;

    typedef struct {
        logic [35:0] hi;
        logic [35:0] lo;
        logic        ovf;
        int          lat;
        int          cap;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cycle = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t expq[$];

    mul_div_seq_if bus();

    mul_div_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Edge counter used to measure start-to-done latency.
    always @(posedge clk) cycle <= cycle + 1;

    // Monitor: compare whenever the DUT presents done.
    always @(negedge clk) begin
        if (rst === 1'b0) checkOutput();
    end

    task automatic checkVal(input string name, input logic [71:0] act, input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (bus.done !== 1'b1) return;
        if (expq.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpectedDone: got done=1, required no pending operation");
            return;
        end
        e = expq.pop_front();
        checkVal("hi", bus.hi, e.hi);
        checkVal("lo", bus.lo, e.lo);
        checkVal("ovf", bus.ovf, e.ovf);
        checkVal("latency", cycle - e.cap, e.lat);
    endtask

    function automatic logic [35:0] rand36();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[35:0];
    endfunction

    // Reference model: plain 72-bit signed arithmetic.
    task automatic modelResult(input logic op, input logic [35:0] ahi, input logic [35:0] alo,
                               input logic [35:0] bb, output exp_t e);
        logic signed [71:0] x;
        logic signed [71:0] y;
        logic signed [71:0] p;
        logic [71:0] dvd;
        logic [71:0] mag;
        logic [71:0] magb;
        logic [71:0] q;
        logic [71:0] r;
        e.lat = 0;
        e.cap = 0;
        if (!op) begin
            x = {{36{alo[35]}}, alo};
            y = {{36{bb[35]}}, bb};
            p = x * y;
            e.hi  = p[71:36];
            e.lo  = p[35:0];
            e.ovf = 1'b0;
        end else begin
            dvd  = {ahi, alo};
            mag  = ahi[35] ? -dvd : dvd;
            y    = {{36{bb[35]}}, bb};
            magb = bb[35] ? -y : y;
            if (magb == 0 || mag >= (magb << 36)) begin
                e.hi  = ahi;
                e.lo  = alo;
                e.ovf = 1'b1;
            end else begin
                q = mag / magb;
                r = mag % magb;
                if (ahi[35] ^ bb[35]) q = -q;
                if (ahi[35]) r = -r;
                e.hi  = q[35:0];
                e.lo  = r[35:0];
                e.ovf = 1'b0;
            end
        end
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy !== 1'b0) begin
            tests++;
            fails++;
            $display("[TB] FAIL idleTimeout: got busy=%b, required 0 within 200 cycles", bus.busy);
        end
    endtask

    // Issue one operation; expected result from the model or from given constants.
    task automatic applyStimulus(input logic op, input logic [35:0] ahi, input logic [35:0] alo,
                                 input logic [35:0] bb, input bit useModel,
                                 input logic [35:0] eHi, input logic [35:0] eLo, input logic eOvf);
        exp_t e;
        waitIdle();
        if (useModel) begin
            modelResult(op, ahi, alo, bb, e);
        end else begin
            e.hi  = eHi;
            e.lo  = eLo;
            e.ovf = eOvf;
        end
        e.lat = !op ? 36 : (e.ovf ? 1 : 38);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a_hi  = ahi;
        bus.a_lo  = alo;
        bus.b     = bb;
        @(posedge clk);
        #1;
        e.cap = cycle;
        expq.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = ~op;
        bus.a_hi  = rand36();
        bus.a_lo  = rand36();
        bus.b     = rand36();
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a_hi  = '0;
        bus.a_lo  = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        checkVal("resetBusy", bus.busy, 0);
        checkVal("resetDone", bus.done, 0);
        checkVal("resetOvf", bus.ovf, 0);
        checkVal("resetHi", bus.hi, 0);
        checkVal("resetLo", bus.lo, 0);
        rst = 1'b0;

        applyStimulus(0, 36'd0, 36'd3, -36'sd5, 0, 36'o777777777777, 36'o777777777761, 0);
        waitIdle();
        repeat (3) @(negedge clk);
        checkVal("holdHi", bus.hi, 36'o777777777777);
        checkVal("holdLo", bus.lo, 36'o777777777761);

        applyStimulus(0, 36'd0, 36'o400000000000, 36'o400000000000, 0, 36'o200000000000, 36'd0, 0);
        applyStimulus(1, 36'd0, 36'd100, 36'd7, 0, 36'd14, 36'd2, 0);
        applyStimulus(1, -36'sd1, -36'sd100, 36'd7, 0, -36'sd14, -36'sd2, 0);
        applyStimulus(1, 36'd3, 36'd77, 36'd0, 0, 36'd3, 36'd77, 1);
        applyStimulus(1, 36'd1, 36'd0, 36'd1, 0, 36'd1, 36'd0, 1);

        applyStimulus(0, 36'd0, 36'd3, -36'sd5, 0, 36'o777777777777, 36'o777777777761, 0);
        repeat (5) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.a_hi  = 36'd0;
        bus.a_lo  = 36'd999;
        bus.b     = 36'd3;
        @(negedge clk);
        bus.start = 1'b0;

        waitIdle();
        applyStimulus(0, 36'd0, 36'd7, 36'd7, 1, '0, '0, 0);
        repeat (8) @(negedge clk);
        #2 rst = 1'b1;
        expq.delete();
        #1;
        checkVal("rstBusy", bus.busy, 0);
        checkVal("rstDone", bus.done, 0);
        checkVal("rstHi", bus.hi, 0);
        checkVal("rstLo", bus.lo, 0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(0, 36'd0, 36'd2, 36'd2, 0, 36'd0, 36'd4, 0);

        applyStimulus(0, 36'd0, 36'd3, 36'd2, 1, '0, '0, 0);
        n = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.done !== 1'b1) begin
            tests++;
            fails++;
            $display("[TB] FAIL doneTimeout: got done=%b, required 1 within 100 cycles", bus.done);
        end
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.a_lo  = 36'd5;
        bus.b     = 36'd5;
        @(negedge clk);
        bus.start = 1'b0;
        checkVal("startInDoneBusy", bus.busy, 0);

        for (int i = 0; i < 40; i++) begin
            logic        op;
            logic [35:0] ahi;
            logic [35:0] alo;
            logic [35:0] bb;
            logic [31:0] t;
            int          mode;
            op   = 1'($urandom_range(0, 1));
            alo  = rand36();
            bb   = rand36();
            mode = $urandom_range(0, 3);
            t    = $urandom();
            if (mode == 0) ahi = rand36();
            else if (mode == 1) ahi = '0;
            else ahi = {{16{t[19]}}, t[19:0]};
            if (mode == 3 && i % 2 == 0) bb = -36'sd13;
            applyStimulus(op, ahi, alo, bb, 1, '0, '0, 0);
        end

        n = 0;
        while (expq.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (expq.size() > 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL drain: got %0d pending results, required 0", expq.size());
        end
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mul_div_seq.md
# mul_div_seq

Iterative signed multiply/divide sequencer for the 36-bit datapath. It drives a ripple-carried 36-bit ALU built from nine mc10181 4-bit slices with function select, boole and carry-in, and it consumes the ALU's F and carry-out each cycle. Products and quotients accumulate in internal AR/MQ registers. The block sits directly downstream of the ALU slices and presents a start/done handshake to the EBOX control.

## Interface
- W, 36, data word width. Fixed; only 36 is supported.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request. Sampled only in IDLE.
- op  in  1  0 = multiply, 1 = divide. Sampled with start.
- a_hi  in  36  divide: dividend high word. Ignored for multiply.
- a_lo  in  36  multiply: multiplicand. Divide: dividend low word.
- b  in  36  multiplier or divisor.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; results valid.
- ovf  out  1  divide overflow or divide by zero. Valid with done, held until next start.
- hi  out  36  product high word, or quotient.
- lo  out  36  product low word, or remainder.

## Operation
- States: IDLE, MSTEP, DSTEP, DFIX, DSIGN, DONE.
- Multiply (radix-2 Booth):
  - Load: AR=0, MQ=b, prev=0, B-operand=a_lo.
  - Each MSTEP inspects {MQ[0],prev}:
    - 10: AR-B, using S=1001, boole=0, cin=1.
    - 01: AR+B, using S=0110, cin=0.
    - else: pass AR, using S=1111, cin=1.
  - Then arithmetic right-shift {AR,MQ,prev} by 1.
  - Shift-in bit is the true sign of the sum: F[35], inverted when the signs of AR and the effective operand match and F[35] differs.
  - After 36 steps, hi=AR and lo=MQ (72-bit two's-complement product).
- Divide (non-restoring, on magnitudes):
  - Load takes |{a_hi,a_lo}| (72-bit two's complement) and |b|.
  - Overflow if b==0 or magnitude-high ≥ |b|. On overflow go straight to DONE with ovf=1, hi=a_hi, lo=a_lo.
  - Partial remainder is 37 bits; bit 36 is formed from the slice-8 carry-out and the operand bit 36.
  - DSTEP ×36: shift {R,Q} left. Subtract |b| if R≥0, add if R<0. Q[0] = ~R_new[36].
  - DFIX: if R<0, R+=|b|.
  - DSIGN: negate Q if sign(a_hi)≠sign(b); negate R if a_hi negative. Negation goes through the ALU with A=0, S=1001, cin=1.
  - Results: hi=quotient, lo=remainder.
- Boundary behaviour:
  - start while busy: ignored. op and operands are not re-sampled.
  - start in the DONE cycle: ignored.
  - hi, lo and ovf hold their values until the next accepted start.
  - rst at any time: immediate return to IDLE, all outputs 0, and the in-flight operation is discarded.

## Timing
- Reset values: busy=0, done=0, ovf=0, hi=0, lo=0. State is IDLE.
- start is captured at edge N.
- busy is high from cycle N+1 through the DONE cycle inclusive.
- Multiply: MSTEP occupies edges N+1..N+36. done=1 in the cycle after edge N+36.
- Divide, normal: DSTEP at N+1..N+36, DFIX at N+37, DSIGN at N+38. done follows edge N+38.
- Divide, overflow: done follows edge N+1.
- The ALU path is fully combinational within one cycle: registers → alu36 → registers. There is no ALU pipeline stage.
- A new start is accepted in the first IDLE cycle after DONE.

## Structure
- Package mul_div_pkg holds:
  - the state enum;
  - W=36;
  - ALU function localparams: FN_ADD (0110/0/0), FN_SUB (1001/0/1), FN_PASSA (1111/0/1), as {S,boole,cin}.
- Sub-module alu36: nine mc10181 instances.
  - Slice i cout feeds slice i+1 cin.
  - Ports: f[35:0] and cout. cg and cp are unused.
- mul_div_seq contains the FSM, the 6-bit step counter, the AR/MQ/R registers, and the |x| and sign logic.

## Test plan
- Multiply 3 × -5 → hi=777777777777₈, lo=777777777761₈. done exactly 37 cycles after start; ovf=0.
- Multiply (-2³⁵) × (-2³⁵) → hi=200000000000₈, lo=0.
- Divide {0,100} / 7 → hi=14, lo=2.
- Divide {-1,-100} / 7 → hi=-14, lo=-2. done 39 cycles after start.
- Divide by b=0, and divide {1,0} / 1 → ovf=1 after 2 cycles; hi and lo equal the dividend.
- rst pulsed at cycle 10 of a multiply → busy, done and hi all 0 immediately. A start pulsed mid-operation is ignored. A subsequent 2 × 2 multiply gives lo=4.
